// File: rtl/adc_acq_pkg.sv
// Shared types and constants for the ADC acquisition capture path.
package adc_acq_pkg;

  localparam int DEF_ADC_WIDTH  = 14;
  localparam int DEF_LANE_WIDTH = 16;

  // lane0 (the earlier sample) occupies the low half of a packed word
  localparam bit LANE0_LSB = 1'b1;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    CAPTURE = 4'b0010,
    FLUSH   = 4'b0100,
    FINISH  = 4'b1000
  } acq_state_t;

endpackage

// File: rtl/adc_acq_capture_packer.sv
// Pairs consecutive ADC samples into two-lane words; a lone trailing sample
// is flushed with a zero upper lane.
module adc_lane_packer
  import adc_acq_pkg::*;
#(
  parameter int ADC_WIDTH  = DEF_ADC_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [ADC_WIDTH-1:0]    sample,
  input  logic                    valid,
  input  logic                    last,
  output logic                    pending,
  output logic [2*LANE_WIDTH-1:0] word,
  output logic                    word_valid
);

  logic                  lane_idx;
  logic [LANE_WIDTH-1:0] lane0;
  logic [LANE_WIDTH-1:0] lane1;

  // word is presented combinationally so the owner can register it with
  // a single cycle of latency from the completing sample
  assign pending    = lane_idx;
  assign lane1      = valid ? LANE_WIDTH'(sample) : '0;
  assign word       = LANE0_LSB ? {lane1, lane0} : {lane0, lane1};
  assign word_valid = lane_idx & (valid | last);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lane_idx <= 1'b0;
      lane0    <= '0;
    end else if (valid) begin
      lane_idx <= ~lane_idx;
      if (!lane_idx) begin
        lane0 <= LANE_WIDTH'(sample);
      end
    end else if (last) begin
      lane_idx <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_acq_capture.sv
// Acquisition-window consumer: captures ADC samples while ACQ_EN is high,
// writes packed words to the FIFO and keeps per-echo status.
module adc_acq_capture
  import adc_acq_pkg::*;
#(
  parameter int ADC_WIDTH        = DEF_ADC_WIDTH,
  parameter int LANE_WIDTH       = DEF_LANE_WIDTH,
  parameter int SAMPLE_CNT_WIDTH = 32,
  parameter int ECHO_CNT_WIDTH   = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ACQ_EN,
  input  logic [ADC_WIDTH-1:0]        ADC_DATA,
  input  logic                        FIFO_FULL,
  output logic                        FIFO_WR,
  output logic [2*LANE_WIDTH-1:0]     FIFO_DATA,
  input  logic                        CLR_STATUS,
  output logic                        BUSY,
  output logic                        ECHO_DONE,
  output logic [SAMPLE_CNT_WIDTH-1:0] SAMPLE_COUNT,
  output logic [ECHO_CNT_WIDTH-1:0]   ECHO_COUNT,
  output logic                        OVERFLOW
);

  acq_state_t              state;
  acq_state_t              state_next;
  logic                    start;
  logic                    capture_more;
  logic                    flush_req;
  logic                    echo_end;
  logic                    pending;
  logic                    word_valid;
  logic [2*LANE_WIDTH-1:0] word;
  logic                    word_write;
  logic                    word_drop;

  adc_lane_packer #(
    .ADC_WIDTH  (ADC_WIDTH),
    .LANE_WIDTH (LANE_WIDTH)
  ) u_packer (
    .CLK        (CLK),
    .RESET      (RESET),
    .sample     (ADC_DATA),
    .valid      (start | capture_more),
    .last       (flush_req),
    .pending    (pending),
    .word       (word),
    .word_valid (word_valid)
  );

  assign word_write = word_valid & ~FIFO_FULL;
  assign word_drop  = word_valid &  FIFO_FULL;

  // FLUSH and FINISH also accept a new first sample so that an echo
  // starting right after a short gap never loses its opening sample
  always_comb begin
    state_next   = state;
    start        = 1'b0;
    capture_more = 1'b0;
    flush_req    = 1'b0;
    echo_end     = 1'b0;
    case (state)
      IDLE: begin
        if (ACQ_EN) begin
          start      = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (ACQ_EN) begin
          capture_more = 1'b1;
        end else begin
          flush_req = 1'b1;
          if (pending) begin
            state_next = FLUSH;
          end else begin
            echo_end   = 1'b1;
            state_next = FINISH;
          end
        end
      end
      FLUSH: begin
        echo_end = 1'b1;
        if (ACQ_EN) begin
          start      = 1'b1;
          state_next = CAPTURE;
        end else begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        if (ACQ_EN) begin
          start      = 1'b1;
          state_next = CAPTURE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      ECHO_DONE <= 1'b0;
      FIFO_WR   <= 1'b0;
      FIFO_DATA <= '0;
    end else begin
      state     <= state_next;
      BUSY      <= (state_next != IDLE);
      ECHO_DONE <= echo_end;
      FIFO_WR   <= word_write;
      if (word_write) begin
        FIFO_DATA <= word;
      end
    end
  end

  // status: a same-cycle set or increment takes priority over CLR_STATUS
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OVERFLOW     <= 1'b0;
      ECHO_COUNT   <= '0;
      SAMPLE_COUNT <= '0;
    end else begin
      if (word_drop) begin
        OVERFLOW <= 1'b1;
      end else if (CLR_STATUS) begin
        OVERFLOW <= 1'b0;
      end

      if (echo_end) begin
        ECHO_COUNT <= CLR_STATUS ? ECHO_CNT_WIDTH'(1) : ECHO_COUNT + ECHO_CNT_WIDTH'(1);
      end else if (CLR_STATUS) begin
        ECHO_COUNT <= '0;
      end

      if (start) begin
        SAMPLE_COUNT <= SAMPLE_CNT_WIDTH'(1);
      end else if (capture_more && (SAMPLE_COUNT != '1)) begin
        SAMPLE_COUNT <= SAMPLE_COUNT + SAMPLE_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc_acq_capture.sv
// Self-checking bench for adc_acq_capture: directed echoes plus randomized
// echoes compared against a sample-list reference model.
module tb_adc_acq_capture;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ACQ_EN;
  logic [13:0] ADC_DATA;
  logic        FIFO_FULL;
  logic        FIFO_WR;
  logic [31:0] FIFO_DATA;
  logic        CLR_STATUS;
  logic        BUSY;
  logic        ECHO_DONE;
  logic [31:0] SAMPLE_COUNT;
  logic [15:0] ECHO_COUNT;
  logic        OVERFLOW;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int last_wr_cycle   = 0;
  int last_done_cycle = 0;
  int obs_done = 0;
  int exp_done = 0;
  logic [31:0] obs_words[$];
  logic [31:0] exp_words[$];
  logic [15:0] exp_echo_count = '0;
  logic        exp_overflow   = 1'b0;
  logic [13:0] stim[64];

  adc_acq_capture dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ACQ_EN       (ACQ_EN),
    .ADC_DATA     (ADC_DATA),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WR      (FIFO_WR),
    .FIFO_DATA    (FIFO_DATA),
    .CLR_STATUS   (CLR_STATUS),
    .BUSY         (BUSY),
    .ECHO_DONE    (ECHO_DONE),
    .SAMPLE_COUNT (SAMPLE_COUNT),
    .ECHO_COUNT   (ECHO_COUNT),
    .OVERFLOW     (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // outputs only move on posedge, so the falling edge is a stable sample point
  always @(negedge CLK) begin
    cycle++;
    if (FIFO_WR) begin
      obs_words.push_back(FIFO_DATA);
      last_wr_cycle = cycle;
    end
    if (ECHO_DONE) begin
      obs_done++;
      last_done_cycle = cycle;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // index of the word whose write is launched at edge e of an n-sample echo
  function automatic int wordAt(input int e, input int n);
    if (e < n && (e % 2) == 1) return e / 2;
    if (e == n && (n % 2) == 1) return n / 2;
    return -1;
  endfunction

  function automatic logic [31:0] packWord(input int w, input int n);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = {2'b00, stim[2*w]};
    hi = (2*w + 1 < n) ? {2'b00, stim[2*w+1]} : 16'h0000;
    return {hi, lo};
  endfunction

  // drives one echo of n samples from stim[] followed by gap idle edges
  task automatic applyStimulus(input int n, input int gap, input int full_mask, input int clr_edge);
    int done_edge;
    int w;
    done_edge = ((n % 2) == 1) ? n + 1 : n;
    for (int e = 0; e < n + gap; e++) begin
      w          = wordAt(e, n);
      ACQ_EN     = (e < n);
      ADC_DATA   = (e < n) ? stim[e] : 14'($urandom);
      FIFO_FULL  = (w >= 0) ? (((full_mask >> w) & 1) != 0) : 1'b0;
      CLR_STATUS = (e == clr_edge);
      if (e == clr_edge) begin
        exp_overflow   = 1'b0;
        exp_echo_count = '0;
      end
      if (w >= 0) begin
        if (FIFO_FULL) exp_overflow = 1'b1;
        else exp_words.push_back(packWord(w, n));
      end
      if (e == done_edge) begin
        exp_echo_count++;
        exp_done++;
      end
      tick();
      if (e < n) begin
        checkOutput("sample_count_run", SAMPLE_COUNT, 64'(e + 1));
        checkOutput("busy_run", BUSY, 1);
      end
    end
    ACQ_EN     = 1'b0;
    FIFO_FULL  = 1'b0;
    CLR_STATUS = 1'b0;
  endtask

  task automatic verifyEcho(input string tag, input bit check_timing, input int exp_count);
    ACQ_EN     = 1'b0;
    FIFO_FULL  = 1'b0;
    CLR_STATUS = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    #1;
    checkOutput({tag, "_nwords"}, obs_words.size(), exp_words.size());
    for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++)
      checkOutput({tag, "_word"}, obs_words[i], exp_words[i]);
    checkOutput({tag, "_ndone"}, obs_done, exp_done);
    checkOutput({tag, "_echo_count"}, ECHO_COUNT, exp_echo_count);
    checkOutput({tag, "_overflow"}, OVERFLOW, exp_overflow);
    checkOutput({tag, "_busy_idle"}, BUSY, 0);
    checkOutput({tag, "_echo_done_idle"}, ECHO_DONE, 0);
    if (exp_count > 0) checkOutput({tag, "_sample_count"}, SAMPLE_COUNT, exp_count);
    if (check_timing) checkOutput({tag, "_done_latency"}, last_done_cycle, last_wr_cycle + 1);
    obs_words.delete();
    exp_words.delete();
    obs_done = 0;
    exp_done = 0;
  endtask

  initial begin
    int n;
    int gap;
    int mask;
    int clr;
    int total;

    RESET      = 1'b1;
    ACQ_EN     = 1'b0;
    ADC_DATA   = '0;
    FIFO_FULL  = 1'b0;
    CLR_STATUS = 1'b0;
    repeat (2) tick();
    checkOutput("rst_fifo_wr", FIFO_WR, 0);
    checkOutput("rst_fifo_data", FIFO_DATA, 0);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_echo_done", ECHO_DONE, 0);
    checkOutput("rst_sample_count", SAMPLE_COUNT, 0);
    checkOutput("rst_echo_count", ECHO_COUNT, 0);
    checkOutput("rst_overflow", OVERFLOW, 0);
    RESET = 1'b0;
    tick();

    $display("[TB] eight-sample echo");
    for (int i = 0; i < 8; i++) stim[i] = 14'(i + 1);
    applyStimulus(8, 2, 0, -1);
    checkOutput("t1_word0_const", exp_words[0], 32'h0002_0001);
    verifyEcho("t1", 1'b1, 8);

    $display("[TB] five-sample echo with flush");
    stim[0] = 14'h3FFF; stim[1] = 14'd1; stim[2] = 14'd2; stim[3] = 14'd3; stim[4] = 14'd4;
    applyStimulus(5, 3, 0, -1);
    verifyEcho("t2", 1'b1, 5);

    $display("[TB] single-sample echo");
    stim[0] = 14'h0ABC;
    applyStimulus(1, 3, 0, -1);
    verifyEcho("t3", 1'b1, 1);

    $display("[TB] second word dropped on full FIFO");
    for (int i = 0; i < 6; i++) stim[i] = 14'($urandom);
    applyStimulus(6, 2, 'b010, -1);
    verifyEcho("t4", 1'b1, 6);
    CLR_STATUS     = 1'b1;
    exp_overflow   = 1'b0;
    exp_echo_count = '0;
    tick();
    CLR_STATUS = 1'b0;
    tick();
    checkOutput("t4_clr_overflow", OVERFLOW, exp_overflow);
    checkOutput("t4_clr_echo_count", ECHO_COUNT, exp_echo_count);

    $display("[TB] clear coinciding with echo end and with overflow");
    for (int i = 0; i < 4; i++) stim[i] = 14'($urandom);
    applyStimulus(4, 2, 0, -1);
    verifyEcho("t5a", 1'b0, 4);
    for (int i = 0; i < 4; i++) stim[i] = 14'($urandom);
    applyStimulus(4, 2, 0, 4);
    verifyEcho("t5b", 1'b0, 4);
    for (int i = 0; i < 4; i++) stim[i] = 14'($urandom);
    applyStimulus(4, 2, 'b10, 3);
    verifyEcho("t5c", 1'b0, 4);

    $display("[TB] reset in the middle of an echo");
    for (int i = 0; i < 8; i++) stim[i] = 14'($urandom);
    exp_words.push_back({2'b00, stim[1], 2'b00, stim[0]});
    for (int e = 0; e < 3; e++) begin
      ACQ_EN   = 1'b1;
      ADC_DATA = stim[e];
      tick();
    end
    RESET = 1'b1;
    #1;
    checkOutput("t6_rst_fifo_wr", FIFO_WR, 0);
    checkOutput("t6_rst_fifo_data", FIFO_DATA, 0);
    checkOutput("t6_rst_busy", BUSY, 0);
    checkOutput("t6_rst_sample_count", SAMPLE_COUNT, 0);
    checkOutput("t6_rst_echo_count", ECHO_COUNT, 0);
    checkOutput("t6_rst_overflow", OVERFLOW, 0);
    exp_echo_count = '0;
    exp_overflow   = 1'b0;
    ADC_DATA = stim[3];
    tick();
    ACQ_EN = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    stim[0] = 14'($urandom);
    stim[1] = 14'($urandom);
    applyStimulus(2, 2, 0, -1);
    verifyEcho("t6", 1'b1, 2);

    $display("[TB] three back-to-back echoes");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) stim[i] = 14'($urandom);
      applyStimulus(4, 1, 0, -1);
    end
    verifyEcho("t7", 1'b1, 4);

    $display("[TB] randomized echoes");
    total = 0;
    for (int k = 0; k < 25; k++) begin
      n    = $urandom_range(1, 11);
      gap  = ((n % 2) == 1) ? $urandom_range(2, 4) : $urandom_range(1, 4);
      mask = ($urandom_range(0, 3) == 0) ? (1 << $urandom_range(0, 5)) : 0;
      clr  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n + gap - 1) : -1;
      for (int i = 0; i < n; i++) stim[i] = 14'($urandom);
      applyStimulus(n, gap, mask, clr);
      total = n;
    end
    verifyEcho("rand", 1'b0, total);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
